// File: rtl/hex_record_sender.sv
// hex_record_sender: formats an address/data pair as an ASCII hex record
// ("AAA: DD\n") and streams it byte by byte over a valid/ready link.
module hex_record_sender #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int CRLF   = 0,
    parameter int UPPER  = 1
) (
    input  logic              CLK_50M,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done
);
    localparam int AD = (ADDR_W + 3) / 4;
    localparam int DD = (DATA_W + 3) / 4;

    typedef enum logic [2:0] {IDLE, ADDR, SEP, DATA, EOL} state_t;

    state_t          r_state, w_state;
    logic [3:0]      r_cnt, w_cnt;
    logic [AD*4-1:0] r_addr, w_addr, w_ash;
    logic [DD*4-1:0] r_data, w_data, w_dsh;
    logic            r_done, w_done, w_xfer, w_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : (UPPER != 0 ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    // Shifting left by the digit index puts the current digit in the top nibble.
    assign w_ash     = r_addr << {r_cnt, 2'b00};
    assign w_dsh     = r_data << {r_cnt, 2'b00};
    assign tx_valid  = r_state != IDLE;
    assign req_ready = r_state == IDLE;
    assign done      = r_done;
    assign w_xfer    = tx_valid & tx_ready;
    assign w_last    = r_cnt == (r_state == ADDR ? 4'(AD - 1) :
                                 r_state == SEP  ? 4'd1 :
                                 r_state == DATA ? 4'(DD - 1) : 4'(CRLF));

    always_comb begin
        tx_data = r_state == ADDR ? hex_char(w_ash[AD*4-1 -: 4]) :
                  r_state == SEP  ? (r_cnt == 4'd0 ? 8'h3A : 8'h20) :
                  r_state == DATA ? hex_char(w_dsh[DD*4-1 -: 4]) :
                  r_state == EOL  ? ((CRLF != 0 && r_cnt == 4'd0) ? 8'h0D : 8'h0A) : 8'h00;
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_addr  = r_addr;
        w_data  = r_data;
        w_done  = 1'b0;
        if (r_state == IDLE) begin
            if (req_valid) begin
                w_state = ADDR;
                w_cnt   = 4'd0;
                w_addr  = (AD*4)'(addr);
                w_data  = (DD*4)'(data);
            end
        end else if (w_xfer) begin
            w_cnt = w_last ? 4'd0 : r_cnt + 4'd1;
            if (w_last) begin
                case (r_state)
                    ADDR:    w_state = SEP;
                    SEP:     w_state = DATA;
                    DATA:    w_state = EOL;
                    default: w_state = IDLE;
                endcase
                w_done = r_state == EOL;
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_done  <= w_done;
        end
    end
endmodule

// File: tb/tb_hex_record_sender.sv
// tb_hex_record_sender: directed checks of the hex record sender with
// hand-computed byte streams for default and alternate parameter sets.
module tb_hex_record_sender;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [11:0] addr = '0;
    logic [7:0]  data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, done;
    logic        rnd = 1'b0, rnd_bit = 1'b1, rdy_fix = 1'b1;

    logic        req_valid1 = 1'b0, req_ready1;
    logic [9:0]  addr1 = '0;
    logic [15:0] data1 = '0;
    logic [7:0]  tx_data1;
    logic        tx_valid1, done1;

    int checks = 0, errors = 0, cyc = 0;
    bq_t q0, q1, want;
    int  qc0[$], qd[$], qa[$], qd1[$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;

    assign tx_ready = rnd ? rnd_bit : rdy_fix;

    hex_record_sender dut (
        .CLK_50M(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .data(data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .done(done)
    );

    hex_record_sender #(.ADDR_W(10), .DATA_W(16), .CRLF(1), .UPPER(0)) dut1 (
        .CLK_50M(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .addr(addr1), .data(data1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(1'b1), .done(done1)
    );

    initial forever #10 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Samples mid-cycle; rst suppresses transfers because it wins at the edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                q0.push_back(tx_data);
                qc0.push_back(cyc);
            end
            if (req_valid && req_ready) qa.push_back(cyc);
            if (done) qd.push_back(cyc);
            if (tx_valid1) q1.push_back(tx_data1);
            if (done1) qd1.push_back(cyc);
            if (pv && !pr) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(pd));
            end
        end
        pv <= tx_valid && !rst;
        pr <= tx_ready;
        pd <= tx_data;
    end

    task automatic clear();
        q0.delete(); qc0.delete(); qd.delete(); qa.delete(); q1.delete(); qd1.delete();
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 300; i++) begin
            if (qd.size() >= n) break;
            @(negedge clk); #1;
        end
        check("done_seen", 32'(qd.size() >= n), 32'd1);
    endtask

    task automatic cmp_bytes(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic send(input logic [11:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; data = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; addr = 12'hFFF; data = 8'h00;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_valid1", 32'(tx_valid1), 32'd0);

        clear();
        send(12'hABC, 8'h5A);
        wait_done(1);
        repeat (4) @(negedge clk);
        #1;
        want = '{8'h41, 8'h42, 8'h43, 8'h3A, 8'h20, 8'h35, 8'h41, 8'h0A};
        cmp_bytes("abc", q0, want);
        if (qc0.size() == 8 && qa.size() == 1 && qd.size() >= 1) begin
            check("abc_first_lat", 32'(qc0[0] - qa[0]), 32'd1);
            check("abc_consec", 32'(qc0[7] - qc0[0]), 32'd7);
            check("abc_done_lat", 32'(qd[0] - qc0[7]), 32'd1);
        end
        check("abc_one_done", 32'(qd.size()), 32'd1);
        check("idle_tx_data", 32'(tx_data), 32'h00);

        clear();
        rnd = 1'b1;
        send(12'h012, 8'hFF);
        wait_done(1);
        rnd = 1'b0;
        want = '{8'h30, 8'h31, 8'h32, 8'h3A, 8'h20, 8'h46, 8'h46, 8'h0A};
        cmp_bytes("stall", q0, want);

        clear();
        @(posedge clk); #1;
        addr = 12'h123; data = 8'h45; req_valid = 1'b1;
        @(posedge clk); #1;
        addr = 12'h678; data = 8'h9C;
        wait_done(1);
        @(posedge clk); #1;
        req_valid = 1'b0; addr = 12'h000; data = 8'h00;
        wait_done(2);
        want = '{8'h31, 8'h32, 8'h33, 8'h3A, 8'h20, 8'h34, 8'h35, 8'h0A,
                 8'h36, 8'h37, 8'h38, 8'h3A, 8'h20, 8'h39, 8'h43, 8'h0A};
        cmp_bytes("b2b", q0, want);
        if (qc0.size() == 16 && qd.size() >= 1 && qa.size() >= 2) begin
            check("b2b_second_lat", 32'(qc0[8] - qd[0]), 32'd1);
            check("b2b_accept_in_done", 32'(qa[1]), 32'(qd[0]));
        end

        clear();
        send(12'hABC, 8'h5A);
        for (int i = 0; i < 50 && q0.size() < 3; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        check("mid_rst_no_done", 32'(qd.size()), 32'd0);
        check("mid_rst_bytes", 32'(q0.size()), 32'd3);
        clear();
        send(12'h0F0, 8'h3C);
        wait_done(1);
        want = '{8'h30, 8'h46, 8'h30, 8'h3A, 8'h20, 8'h33, 8'h43, 8'h0A};
        cmp_bytes("after_rst", q0, want);

        clear();
        @(posedge clk); #1;
        addr1 = 10'h3FF; data1 = 16'hBEEF; req_valid1 = 1'b1;
        @(posedge clk); #1;
        req_valid1 = 1'b0; addr1 = 10'h000; data1 = 16'h0000;
        for (int i = 0; i < 100 && qd1.size() == 0; i++) begin
            @(negedge clk); #1;
        end
        check("p1_done_seen", 32'(qd1.size()), 32'd1);
        want = '{8'h33, 8'h66, 8'h66, 8'h3A, 8'h20, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A};
        cmp_bytes("p1", q1, want);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_record_sender.md
HEX_RECORD_SENDER -- requirements
Module: hex_record_sender

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, address width in bits (1..32).
REQ-002 SHALL have parameter DATA_W, default 8, data width in bits (1..32).
REQ-003 SHALL have parameter CRLF, default 0: 0 ends each record with LF only; 1 ends it with CR then LF.
REQ-004 SHALL have parameter UPPER, default 1: 1 uses hex letters 'A'-'F'; 0 uses 'a'-'f'.
REQ-005 SHALL derive AD = ceil(ADDR_W/4) address digits and DD = ceil(DATA_W/4) data digits.
REQ-006 SHALL provide: CLK_50M  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL provide: rst  in  1  reset; synchronous, active-high.
REQ-008 SHALL provide: req_valid  in  1  a record request is present.
REQ-009 SHALL provide: req_ready  out  1  block can accept a request.
REQ-010 SHALL provide: addr  in  ADDR_W  address to format.
REQ-011 SHALL provide: data  in  DATA_W  data to format.
REQ-012 SHALL provide: tx_data  out  8  ASCII byte to the UART transmitter.
REQ-013 SHALL provide: tx_valid  out  1  tx_data holds a valid byte.
REQ-014 SHALL provide: tx_ready  in  1  UART transmitter accepts a byte.
REQ-015 SHALL provide: done  out  1  one-cycle pulse when a record is complete.

Function
REQ-016 SHALL accept a request in any cycle with req_valid=1 and req_ready=1, and capture addr and data in that cycle; later input changes SHALL NOT affect the record.
REQ-017 SHALL drive req_ready=1 only in state IDLE.
REQ-018 SHALL emit each record as: AD address hex digits (most significant first), ':' (0x3A), ' ' (0x20), DD data hex digits (most significant first), then 0x0D if CRLF=1, then 0x0A.
REQ-019 SHALL map each nibble n as follows: 0-9 -> 0x30+n; 10-15 -> 0x41+n-10 when UPPER=1, or 0x61+n-10 when UPPER=0.
REQ-020 SHALL zero-extend the value when a width is not a multiple of 4, so the top digit covers only the valid bits.
REQ-021 SHALL use the states IDLE -> ADDR -> SEP -> DATA -> EOL -> IDLE; a per-state digit/byte counter SHALL select the current byte.
REQ-022 SHALL transfer a byte only in a cycle with tx_valid=1 and tx_ready=1; the FSM and counter SHALL advance only on a transfer.
REQ-023 SHALL hold tx_data stable and keep tx_valid=1 while tx_valid=1 and tx_ready=0.
REQ-024 SHALL assert tx_valid in the cycle after a request is accepted, carrying the first address digit.
REQ-025 SHALL, in the cycle after the last byte transfer, pulse done=1 for exactly one cycle with state IDLE and req_ready=1.
REQ-026 SHALL allow back-to-back records: a request accepted in the done cycle SHALL produce its first byte in the following cycle; minimum period is AD+DD+4+CRLF cycles per record.
REQ-027 SHALL drive tx_valid=0 in IDLE; tx_data SHALL then be 0x00.
REQ-028 SHALL hold tx_ready=1 continuously without losing or duplicating bytes; a tx_ready=1 seen while tx_valid=0 SHALL have no effect.

Reset
REQ-029 SHALL, in the cycle after rst=1 is sampled, set state=IDLE, counters=0, tx_valid=0, tx_data=0x00, done=0 and req_ready=1.
REQ-030 SHALL abandon any partial record when rst=1 arrives mid-record; that record SHALL produce no done pulse and no further bytes.
REQ-031 SHALL let rst take priority over a req_valid or a byte transfer in the same cycle.

Verification
REQ-032 Default parameters, addr=0xABC, data=0x5A, tx_ready always 1 -> bytes 41 42 43 3A 20 35 41 0A in 8 consecutive cycles, then a done pulse.
REQ-033 tx_ready toggling randomly with addr=0x012, data=0xFF -> bytes 30 31 32 3A 20 46 46 0A with no loss or duplication, and tx_data stable during every stall.
REQ-034 ADDR_W=10, DATA_W=16, CRLF=1, UPPER=0, addr=0x3FF, data=0xBEEF -> bytes 33 66 66 3A 20 62 65 65 66 0D 0A.
REQ-035 Two requests back-to-back, with req_valid held high -> second record's first byte appears in the cycle after the first done; addr changed during the first record does not corrupt it.
REQ-036 rst=1 asserted after the 3rd byte transfer -> next cycle tx_valid=0 and req_ready=1; no done pulse; the next request emits a complete, correct record.
